// File: rtl/scmp_bus_pkg.sv
// Shared types and constants for the scmp bus controller.
// The FSM encoding is exported so benches and checkers can decode the state output.
package scmp_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } bus_state_t;

    // Bit positions of the {H,D,I,R} flags inside the flags output.
    localparam int FLAG_H = 3;
    localparam int FLAG_D = 2;
    localparam int FLAG_I = 1;
    localparam int FLAG_R = 0;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/scmp_reset_gen.sv
// Button synchroniser and reset stretcher producing the core reset.
// The core stays in reset until the counter MSB sets after the button is released.
module scmp_reset_gen #(
    parameter int RST_CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic cpu_rst_n
);

    logic [1:0]           sync;
    logic [RST_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= 2'b00;
            cnt       <= '0;
            cpu_rst_n <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1]) begin
                cnt <= '0;
            end else if (!cnt[RST_CNT_W-1]) begin
                cnt <= cnt + 1'b1;
            end
            // Masking with the synchronised button drops the reset in the same
            // cycle the counter is cleared, keeping the button-to-reset path at 3 cycles.
            cpu_rst_n <= cnt[RST_CNT_W-1] & ~sync[1];
        end
    end

endmodule

// File: rtl/scmp_bus_ctrl.sv
// Bus controller between the scmp core and a synchronous byte memory:
// bank/flag latch, map and write-protect masks, fault counting and core reset.
module scmp_bus_ctrl
    import scmp_bus_pkg::*;
#(
    parameter int          LO_W      = 12,
    parameter int          BANK_W    = 4,
    parameter logic [15:0] MAP_MASK  = 16'hFFFF,
    parameter logic [15:0] WR_MASK   = 16'h0FFA,
    parameter int          RST_CNT_W = 16,
    parameter int          FAULT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn,
    output logic                   cpu_rst_n,
    input  logic                   ads_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic [LO_W-1:0]        addr,
    input  logic [7:0]             d_from_cpu,
    output logic [7:0]             d_to_cpu,
    output logic                   rd_valid,
    output logic [BANK_W-1:0]      bank,
    output logic [3:0]             flags,
    output logic [BANK_W+LO_W-1:0] mem_addr,
    output logic                   mem_we,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    output logic                   fault,
    output logic [FAULT_W-1:0]     fault_cnt,
    input  logic                   fault_clr,
    output bus_state_t             bus_state
);

    bus_state_t        state, state_next;
    logic              latch, wr_entry, wr_ok, fault_event, rd_capture, rd_done;
    logic              bank_mapped, bank_writable, we_q;
    logic [BANK_W-1:0] bank_next;
    logic [3:0]        flags_next;

    scmp_reset_gen #(.RST_CNT_W(RST_CNT_W)) u_reset_gen (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .cpu_rst_n (cpu_rst_n)
    );

    assign bank_mapped   = MAP_MASK[bank];
    assign bank_writable = WR_MASK[bank];
    assign bus_state     = state;
    assign mem_we        = we_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!cpu_rst_n) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (!ads_n) state_next = ST_ADDR;
                ST_ADDR: begin
                    if (!ads_n)     state_next = ST_ADDR;
                    else if (!wr_n) state_next = ST_WRITE;
                    else if (!rd_n) state_next = ST_READ;
                end
                ST_READ:  if (rd_valid && rd_n) state_next = ST_IDLE;
                ST_WRITE: if (wr_n) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        latch       = cpu_rst_n && !ads_n && (state == ST_IDLE || state == ST_ADDR);
        wr_entry    = cpu_rst_n && (state == ST_ADDR) && ads_n && !wr_n;
        wr_ok       = wr_entry && bank_mapped && bank_writable;
        fault_event = wr_entry && !(bank_mapped && bank_writable);
        rd_capture  = cpu_rst_n && (state == ST_READ) && !rd_valid;
        rd_done     = cpu_rst_n && (state == ST_READ) && rd_valid && rd_n;
        bank_next   = bank;
        flags_next  = flags;
        if (!cpu_rst_n) begin
            bank_next  = '0;
            flags_next = '0;
        end else if (latch) begin
            bank_next               = d_from_cpu[BANK_W-1:0];
            flags_next[FLAG_H]      = d_from_cpu[7];
            flags_next[FLAG_D]      = d_from_cpu[6];
            flags_next[FLAG_I]      = d_from_cpu[5];
            flags_next[FLAG_R]      = d_from_cpu[4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank      <= '0;
            flags     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            rd_valid  <= 1'b0;
            d_to_cpu  <= UNMAPPED_DATA;
        end else begin
            bank     <= bank_next;
            flags    <= flags_next;
            // Address is presented a cycle ahead so the registered memory output
            // is ready when the read data is captured.
            mem_addr <= {bank_next, addr};
            we_q     <= wr_ok;
            if (wr_ok) mem_wdata <= d_from_cpu;
            if (!cpu_rst_n || rd_done) begin
                rd_valid <= 1'b0;
            end else if (rd_capture) begin
                rd_valid <= 1'b1;
                d_to_cpu <= bank_mapped ? mem_rdata : UNMAPPED_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else if (fault_clr) begin
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else if (fault_event) begin
            fault <= 1'b1;
            if (fault_cnt != {FAULT_W{1'b1}}) fault_cnt <= fault_cnt + 1'b1;
        end
    end

endmodule

// File: doc/scmp_bus_ctrl.md
# scmp_bus_ctrl

Parametrised bus controller between the `scmp` core and a synchronous single-port byte memory. Latches the bank nibble and the H/D/I/R flags from the address strobe. Applies per-bank map and write-protect masks, with exactly one write strobe per WR_n pulse. Also counts protection faults and generates the stretched CPU reset from a button. Replaces the ad-hoc glue in board tops; boards set the masks and the debounce width by parameter.

## Interface
Parameters:
- `LO_W`, 12: CPU low address width.
- `BANK_W`, 4: bank bits latched from `d_from_cpu[BANK_W-1:0]` on ADS.
- `MAP_MASK`, 16'hFFFF: bit b set means bank b is mapped; an unmapped bank reads 8'hFF and writes are dropped.
- `WR_MASK`, 16'h0FFA: bit b set means bank b is writable (banks 1 and 3–11 by default).
- `RST_CNT_W`, 16: width of the reset stretch counter.
- `FAULT_W`, 8: width of the saturating fault counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: single clock; all CPU strobes are synchronous to it.
  - `rst` in 1: asynchronous, active-high.
- Reset generator:
  - `btn` in 1: asynchronous reset request, active-high.
  - `cpu_rst_n` out 1: reset to the core.
- CPU side:
  - `ads_n`, `rd_n`, `wr_n` in 1 each: core bus strobes.
  - `addr` in LO_W: core low address.
  - `d_from_cpu` in 8: core output data.
  - `d_to_cpu` out 8: read data.
  - `rd_valid` out 1: `d_to_cpu` is valid.
- State outputs:
  - `bank` out BANK_W: latched bank nibble.
  - `flags` out 4: latched {H,D,I,R}.
- Memory side:
  - `mem_addr` out BANK_W+LO_W = {bank, addr}.
  - `mem_we` out 1.
  - `mem_wdata` out 8.
  - `mem_rdata` in 8: registered memory output, 1-cycle latency.
- Fault reporting:
  - `fault` out 1: sticky protection fault.
  - `fault_cnt` out FAULT_W: saturating fault count.
  - `fault_clr` in 1: clears `fault` and `fault_cnt`.

## Operation
- FSM states: IDLE, ADDR, READ, WRITE.
- IDLE:
  - `ads_n`=0: latch `bank` and `flags` from `d_from_cpu`, go to ADDR.
  - Any other strobe is ignored.
- ADDR:
  - `ads_n`=0: re-latch, stay in ADDR.
  - `wr_n`=0: go to WRITE. Write wins over read; a simultaneous `rd_n`=0 is not a fault.
  - Otherwise `rd_n`=0: go to READ.
- READ:
  - `mem_addr` is driven from entry.
  - Cycle 1: `d_to_cpu` = `mem_rdata`, or 8'hFF if the bank is unmapped; `rd_valid`=1.
  - Cycle 2 onward: `d_to_cpu` holds the registered value until `rd_n`=1, then go to IDLE and drop `rd_valid`.
- WRITE:
  - Entry cycle, bank mapped and writable: `mem_we`=1 for exactly that cycle, `mem_wdata`=`d_from_cpu`.
  - Entry cycle, bank unmapped or protected: no `mem_we`; `fault` sets and `fault_cnt` increments, saturating at all-ones.
  - Stay in WRITE until `wr_n`=1, then go to IDLE.
- `fault_clr` wins over a same-cycle fault event.
- `flags` and `bank` are forced to 0 while `cpu_rst_n`=0. The FSM also returns to IDLE in that case.
- Reset generator:
  - `btn` is synchronised through 2 flops.
  - While the synchronised `btn` is high, the counter is cleared.
  - Otherwise the counter increments while its MSB is 0.
  - `cpu_rst_n` is the MSB, registered.

## Timing
- `rst` asserted, all outputs asynchronously:
  - `cpu_rst_n`=0, `bank`=0, `flags`=0, `mem_we`=0.
  - `rd_valid`=0, `d_to_cpu`=8'hFF, `fault`=0, `fault_cnt`=0.
  - `mem_addr`=0, `mem_wdata`=0, counter=0, FSM=IDLE.
- `rst` deasserted with `btn` low: `cpu_rst_n` rises 2^(RST_CNT_W-1)+1 cycles later.
- `btn` rising edge: `cpu_rst_n` falls 3 cycles later (2 sync + 1 register).
- Bank latch: visible on `bank` and `mem_addr` the cycle after `ads_n` is sampled low.
- Read: `rd_valid` one cycle after entering READ.
- Write: `mem_we` is combinational from the WRITE entry registers and lasts exactly one cycle, whatever the length of `wr_n`.
- `rst` asserted mid-write: `mem_we` drops immediately; no retry after reset.
- `fault_cnt` at max plus another fault: value holds and `fault` stays 1.

## Structure
- Package `scmp_bus_pkg` holds:
  - the `bus_state_t` enum;
  - `FLAG_H`/`FLAG_D`/`FLAG_I`/`FLAG_R` bit indices;
  - `UNMAPPED_DATA`=8'hFF.
- Sub-module `scmp_reset_gen`: `btn` synchroniser, stretch counter and `cpu_rst_n` register, parameter `RST_CNT_W`.
- The memory array is outside this block.

## Test plan
- Reset stretch: RST_CNT_W=4; release `rst` with `btn`=0 → `cpu_rst_n`=1 exactly 9 cycles later. Pulse `btn` 1 cycle → `cpu_rst_n`=0 3 cycles later and stays 0 for at least 8 further cycles.
- Latch: `ads_n`=0 with `d_from_cpu`=8'hA3 → `bank`=3, `flags`=4'hA, `mem_addr`[15:12]=3 the next cycle.
- Write pulse: bank 1, `addr`=12'h123, `wr_n` low 5 cycles, data 8'h5C → exactly one `mem_we` with `mem_addr`=16'h1123 and `mem_wdata`=8'h5C.
- Protection: write to bank 0 (or bank 2 and 12) → no `mem_we`, `fault`=1, `fault_cnt` +1 each. With FAULT_W=2, five faults → `fault_cnt`=3. `fault_clr` asserted in the same cycle as a fault → `fault_cnt`=0.
- Read/unmapped: memory preloaded with 8'h42 at 16'hC000, read it → `rd_valid` after 1 cycle, `d_to_cpu`=8'h42. MAP_MASK clearing bank 14, read bank 14 → 8'hFF.
- Mid-cycle reset: assert `rst` during WRITE → `mem_we` drops in the same cycle. After release, FSM is in IDLE and the held `wr_n`=0 produces no write.
